// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with a bit-serial shifter that moves one position per cycle.
// Optional build macro ALU_PIPE_SAT_EN saturates ADD/SUB results on signed overflow.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       flags,
  output logic             err
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_e;

  state_e state, state_next;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [SHW-1:0]   cnt_q;
  logic             flag_z, flag_v, flag_n;

  logic             accept;
  logic             is_shift;
  logic             shift_now;
  logic [SHW-1:0]   amt;

  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH-1:0] arith_res;

  logic [WIDTH-1:0] acc_data;
  logic             acc_arith;
  logic             acc_rsvd;

  // One position of the serial shifter; the op captured at acceptance picks the direction.
  function automatic logic [WIDTH-1:0] shift_step(input logic [2:0] kind,
                                                  input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    case (kind)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {v[0], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign flags     = {flag_z, flag_v, flag_n};

  assign accept    = in_valid && in_ready;
  assign amt       = in_b[SHW-1:0];
  assign is_shift  = (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  assign shift_now = is_shift && (amt != '0);
  assign shift_nxt = shift_step(op_q, shift_q);

  // SUB is formed as a + ~b + 1 so both ops share one adder and one overflow rule.
  assign sub_sel = (op == OP_SUB);
  assign b_eff   = sub_sel ? ~in_b : in_b;
  assign sum     = in_a + b_eff + {{(WIDTH-1){1'b0}}, sub_sel};
  assign ovf     = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);

`ifdef ALU_PIPE_SAT_EN
  assign arith_res = !ovf ? sum :
                     (in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign arith_res = sum;
`endif

  always_comb begin
    acc_data  = '0;
    acc_arith = 1'b0;
    acc_rsvd  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        acc_data  = arith_res;
        acc_arith = 1'b1;
      end
      OP_NAND: acc_data = ~(in_a & in_b);
      OP_XOR:  acc_data = in_a ^ in_b;
      OP_SLL, OP_SRA, OP_ROR: acc_data = in_a;
      default: acc_rsvd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = shift_now ? SHIFT : HOLD;
        end
      end
      SHIFT: begin
        if (cnt_q == SHW'(1)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // N follows the wrapped sum MSB even when saturating, so flags match across builds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      out_data <= '0;
      flag_z   <= 1'b0;
      flag_v   <= 1'b0;
      flag_n   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= op;
            if (shift_now) begin
              shift_q <= in_a;
              cnt_q   <= amt;
            end else begin
              out_data <= acc_data;
              if (!acc_rsvd) begin
                flag_z <= (acc_data == '0);
              end
              if (acc_arith) begin
                flag_v <= ovf;
                flag_n <= sum[WIDTH-1];
              end
              if (acc_rsvd || (acc_arith && ovf)) begin
                err <= 1'b1;
              end
            end
          end
        end
        SHIFT: begin
          shift_q <= shift_nxt;
          cnt_q   <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            out_data <= shift_nxt;
            flag_z   <= (shift_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random ops against a behavioural model of alu_pipe (WIDTH=16),
// plus literal expectations for latency, backpressure, reserved op and reset.
module tb_alu_pipe;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    flags;
  logic          err;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         rsvd;
    logic         arith;
    logic         v;
    logic         n;
    logic [4:0]   lat;
  } res_t;

  logic         m_valid = 1'b0;
  int           m_wait  = 0;
  logic [W-1:0] m_data  = '0;
  logic         m_z = 1'b0, m_v = 1'b0, m_n = 1'b0, m_err = 1'b0;
  res_t         m_pend  = '0;

  // Result of an op straight from integer arithmetic; lat is the number of shift cycles.
  function automatic res_t predict(input logic [2:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    res_t r;
    int sa, sb, s, k;
    logic [W-1:0] wrapped;
    r  = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    k  = int'(b[3:0]);
    case (o)
      3'd0, 3'd1: begin
        s = (o == 3'd0) ? sa + sb : sa - sb;
        wrapped = s[W-1:0];
        r.arith = 1'b1;
        r.v = (s > 32767) || (s < -32768);
        r.n = wrapped[W-1];
        r.data = wrapped;
`ifdef ALU_PIPE_SAT_EN
        if (r.v) r.data = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
      end
      3'd2: r.data = ~(a & b);
      3'd3: r.data = a ^ b;
      3'd4: begin r.data = a << k; r.lat = 5'(k); end
      3'd5: begin r.data = 16'($signed(a) >>> k); r.lat = 5'(k); end
      3'd6: begin r.data = (k == 0) ? a : ((a >> k) | (a << (W - k))); r.lat = 5'(k); end
      default: r.rsvd = 1'b1;
    endcase
    return r;
  endfunction

  task automatic model_finish(input res_t r);
    m_data  <= r.data;
    m_valid <= 1'b1;
    if (!r.rsvd) m_z <= (r.data == '0);
    if (r.arith) begin
      m_v <= r.v;
      m_n <= r.n;
    end
    if (r.rsvd || (r.arith && r.v)) m_err <= 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_wait  <= 0;
      m_data  <= '0;
      m_z     <= 1'b0;
      m_v     <= 1'b0;
      m_n     <= 1'b0;
      m_err   <= 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) model_finish(m_pend);
    end else if (in_valid) begin
      m_pend <= predict(op, in_a, in_b);
      m_wait <= int'(predict(op, in_a, in_b).lat);
      if (predict(op, in_a, in_b).lat == 5'd0) model_finish(predict(op, in_a, in_b));
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("in_ready", 32'(in_ready), 32'(!m_valid && (m_wait == 0)));
      checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
      checkOutput("flags", 32'(flags), 32'({m_z, m_v, m_n}));
      checkOutput("err", 32'(err), 32'(m_err));
      if (m_valid) checkOutput("out_data", 32'(out_data), 32'(m_data));
    end
  end

  // Issue one op, measure latency, optionally hold off out_ready, then release the result.
  task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int hold, input logic lit,
                               input logic [W-1:0] lit_data, input logic [2:0] lit_flags,
                               input logic lit_err, input int lit_lat);
    int tries;
    int lat;
    tries = 0;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!in_ready) checkOutput({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op = o;
    in_a = a;
    in_b = b;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = ~a;
    in_b = ~b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) checkOutput({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
    if (lit) begin
      checkOutput({tag, "_latency"}, 32'(lat), 32'(lit_lat));
      checkOutput({tag, "_data"}, 32'(out_data), 32'(lit_data));
      checkOutput({tag, "_flags"}, 32'(flags), 32'(lit_flags));
      checkOutput({tag, "_err"}, 32'(err), 32'(lit_err));
    end
    #1;
    in_valid = 1'b1;
    op = 3'b000;
    in_a = 16'h0101;
    in_b = 16'h0202;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (lit) begin
        checkOutput({tag, "_hold_data"}, 32'(out_data), 32'(lit_data));
        checkOutput({tag, "_hold_flags"}, 32'(flags), 32'(lit_flags));
        checkOutput({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      end
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (lit) checkOutput({tag, "_released"}, 32'(in_ready), 32'd1);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    op = '0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    #1;

    applyStimulus("sub_zero", 3'b001, 16'h0005, 16'h0005, 3, 1'b1, 16'h0000, 3'b100, 1'b0, 1);
`ifdef ALU_PIPE_SAT_EN
    applyStimulus("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 0, 1'b1, 16'h7FFF, 3'b011, 1'b1, 1);
`else
    applyStimulus("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 0, 1'b1, 16'h8000, 3'b011, 1'b1, 1);
`endif
    applyStimulus("xor", 3'b011, 16'h00FF, 16'h0F0F, 1, 1'b1, 16'h0FF0, 3'b011, 1'b1, 1);
    applyStimulus("nand", 3'b010, 16'hFFFF, 16'hFFFF, 0, 1'b1, 16'h0000, 3'b111, 1'b1, 1);
    applyStimulus("sra4", 3'b101, 16'h8000, 16'h0004, 0, 1'b1, 16'hF800, 3'b011, 1'b1, 5);
    applyStimulus("ror1", 3'b110, 16'h0001, 16'h0001, 0, 1'b1, 16'h8000, 3'b011, 1'b1, 2);
    applyStimulus("sll0", 3'b100, 16'h1234, 16'hFFF0, 0, 1'b1, 16'h1234, 3'b011, 1'b1, 1);
    applyStimulus("add", 3'b000, 16'h1234, 16'h1111, 0, 1'b1, 16'h2345, 3'b000, 1'b1, 1);
    applyStimulus("rsvd", 3'b111, 16'h1234, 16'h5678, 0, 1'b1, 16'h0000, 3'b000, 1'b1, 1);
`ifdef ALU_PIPE_SAT_EN
    applyStimulus("sub_ovf", 3'b001, 16'h8000, 16'h0001, 0, 1'b1, 16'h8000, 3'b010, 1'b1, 1);
`else
    applyStimulus("sub_ovf", 3'b001, 16'h8000, 16'h0001, 0, 1'b1, 16'h7FFF, 3'b010, 1'b1, 1);
`endif
    applyStimulus("sll3", 3'b100, 16'h0003, 16'h0003, 2, 1'b1, 16'h0018, 3'b010, 1'b1, 4);
    applyStimulus("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 0, 1'b1, 16'h0000, 3'b100, 1'b1, 1);

    for (int i = 0; i < 24; i++) begin
      applyStimulus("rand", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 2)), 1'b0, '0, '0, 1'b0, 0);
    end

    // Reset in the middle of a long shift must discard the op entirely.
    while (!in_ready) begin
      @(negedge clk);
      #1;
    end
    in_valid = 1'b1;
    op = 3'b100;
    in_a = 16'hFFFF;
    in_b = 16'h000F;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    checkOutput("midrst_flags", 32'(flags), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("midrst_no_result", 32'(out_valid), 32'd0);
    #1;

    applyStimulus("rsvd_err", 3'b111, 16'hAAAA, 16'h5555, 0, 1'b1, 16'h0000, 3'b000, 1'b1, 1);
    applyStimulus("err_sticky", 3'b000, 16'h0001, 16'h0002, 0, 1'b1, 16'h0003, 3'b000, 1'b1, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal range 4..32.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; always derived from WIDTH, never overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  3  000 ADD, 001 SUB, 010 NAND, 011 XOR, 100 SLL, 101 SRA, 110 ROR, 111 reserved.
REQ-008 in_a  input  WIDTH  operand A; shift source for 100-110.
REQ-009 in_b  input  WIDTH  operand B; bits [SHW-1:0] are the shift amount for 100-110.
REQ-010 out_valid  output  1  result held on out_data.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_data  output  WIDTH  registered result.
REQ-013 flags  output  3  registered {Z,V,N}.
REQ-014 err  output  1  sticky error: overflow or reserved opcode seen since reset.

Function
REQ-015 FSM states: IDLE, SHIFT, HOLD; in_ready=1 only in IDLE.
REQ-016 Handshake: request accepted when in_valid&&in_ready; op, in_a and in_b are captured at acceptance and ignored afterwards.
REQ-017 ADD/SUB/NAND/XOR/reserved: IDLE->HOLD on acceptance; out_valid is asserted the next cycle (latency 1).
REQ-018 Shifts with amount 0: IDLE->HOLD with out_data=in_a (latency 1).
REQ-019 Shifts with amount k>0: IDLE->SHIFT; one bit position per cycle; SHIFT->HOLD after k SHIFT cycles; out_valid is asserted k+1 cycles after acceptance.
REQ-020 SLL fills with 0; SRA replicates the MSB; ROR moves bit 0 into the MSB.
REQ-021 HOLD: out_valid=1, and out_data/flags stay stable until out_ready=1; then HOLD->IDLE. No bypass: at most one new request per two cycles.
REQ-022 ADD/SUB: WIDTH-bit two's complement; SUB = in_a + ~in_b + 1; V = signed overflow; N = result MSB.
REQ-023 Z is updated on every completed op (result==0); V and N are updated only on ADD/SUB and hold otherwise.
REQ-024 Reserved op 111: out_data=0, flags unchanged, err set at completion.
REQ-025 err sets on any ADD/SUB with V=1 and clears only on reset.
REQ-026 Flags and err update in the same cycle that out_valid rises.
REQ-027 out_valid=1 with out_ready=1 and in_valid=1 in HOLD: the request is not accepted that cycle (in_ready=0).

Reset
REQ-028 rst=1 forces IDLE immediately, regardless of the clock.
REQ-029 Reset values: out_valid=0, out_data=0, flags=000, err=0, shift counter=0, in_ready=1 once rst deasserts.
REQ-030 Reset during SHIFT or HOLD discards the operation; no result is ever presented for it.

Configuration
REQ-031 Macro ALU_PIPE_SAT_EN defined: on ADD/SUB overflow, out_data saturates to the signed max (0111..1) for positive overflow or the signed min (1000..0) for negative overflow; V and err are still set.
REQ-032 Macro ALU_PIPE_SAT_EN undefined: out_data is the wrapped WIDTH-bit sum; all other behaviour is identical.

Verification
REQ-033 WIDTH=16, ADD 0x7FFF+0x0001 -> out_valid at +1 cycle; out_data=0x8000 without SAT_EN or 0x7FFF with SAT_EN; V=1, N=1 without SAT_EN, err=1.
REQ-034 SUB 0x0005-0x0005 -> out_data=0x0000, Z=1, V=0, N=0; err stays 0 after reset.
REQ-035 SRA in_a=0x8000, amount 4 -> out_valid exactly 5 cycles after acceptance, out_data=0xF800; ROR 0x0001 by 1 -> 0x8000.
REQ-036 Backpressure: out_ready=0 for 3 cycles in HOLD -> out_data/flags stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-037 rst pulsed mid-way through SLL by 15 -> out_valid=0 immediately, no result produced, all outputs at reset values, in_ready=1 after deassert.
REQ-038 op=111 -> out_data=0, flags unchanged, err=1 and stays 1 through later error-free ops.
